// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: branch flush, load-use stall
// and a cancellable halt drain sequencer for the 5-stage core.
module hazard_ctrl_unit #(
  parameter int REG_W = 4,
  parameter int OPC_W = 4,
  parameter logic [OPC_W-1:0] HALT_OPC = OPC_W'('hF),
  parameter int BR_FLUSH_CYC = 3,
  parameter int LD_STALL_CYC = 1,
  parameter int HALT_DRAIN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] id_opcode,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_mem_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_branch_taken,
  output logic             branch_flush,
  output logic             load_stall,
  output logic             halt_stall_pc,
  output logic             halt,
  output logic             stall_busy
);

  localparam int BW =
    $clog2(BR_FLUSH_CYC > 2 ? BR_FLUSH_CYC : 2);
  localparam int LW =
    $clog2(LD_STALL_CYC > 2 ? LD_STALL_CYC : 2);
  localparam int HW =
    $clog2(HALT_DRAIN > 2 ? HALT_DRAIN : 2);

  typedef enum logic [1:0] {
    RUN, DRAIN, HALTED
  } st_e;

  st_e           st_q, st_d;
  logic [BW-1:0] br_q, br_d;
  logic [LW-1:0] ld_q, ld_d;
  logic [HW-1:0] hc_q, hc_d;
  logic          flush, stall, busy;
  logic          hz_raw, hz, hlt_dec;
  logic          hsp, hlt;

  // Branch flush window, reloaded on every taken branch
  always_comb begin
    flush = mem_branch_taken | (br_q != '0);
    br_d  = br_q;
    if (mem_branch_taken)
      br_d = BW'(BR_FLUSH_CYC - 1);
    else if (br_q != '0)
      br_d = br_q - BW'(1);
  end

  // Store data is forwarded mem-to-mem, so its rs never stalls
  assign hz_raw = ex_mem_read &
    ((id_uses_rs & ~id_mem_write & (id_rs == ex_rt)) |
     (id_uses_rt & (id_rt == ex_rt)));
  assign hz = hz_raw & ~flush;

  // Load-use stall: first cycle from hz, remainder counted
  always_comb begin
    stall = 1'b0;
    busy  = 1'b0;
    ld_d  = ld_q;
    if (mem_branch_taken) begin
      ld_d = '0;
    end else if (ld_q != '0) begin
      stall = 1'b1;
      busy  = 1'b1;
      ld_d  = ld_q - LW'(1);
    end else if (hz) begin
      stall = 1'b1;
      ld_d  = LW'(LD_STALL_CYC - 1);
    end
  end

  assign hlt_dec = (id_opcode == HALT_OPC) &
                   ~flush & ~stall;

  // Halt FSM next state and drain counter
  always_comb begin
    st_d = st_q;
    hc_d = hc_q;
    unique case (st_q)
      RUN: begin
        if (hlt_dec) begin
          st_d = DRAIN;
          hc_d = HW'(HALT_DRAIN - 1);
        end
      end
      DRAIN: begin
        if (mem_branch_taken) begin
          st_d = RUN;
          hc_d = '0;
        end else if (hc_q == '0) begin
          st_d = HALTED;
        end else begin
          hc_d = hc_q - HW'(1);
        end
      end
      HALTED: st_d = HALTED;
      default: st_d = RUN;
    endcase
  end

  // Halt FSM outputs; last drain cycle already reports halt
  always_comb begin
    hsp = 1'b0;
    hlt = 1'b0;
    unique case (st_q)
      RUN:    hsp = hlt_dec;
      DRAIN: begin
        hsp = ~mem_branch_taken;
        hlt = ~mem_branch_taken & (hc_q == '0);
      end
      HALTED: begin
        hsp = 1'b1;
        hlt = 1'b1;
      end
      default: hsp = 1'b0;
    endcase
  end

  // Everything is forced low while reset is held
  assign branch_flush  = ~rst & flush;
  assign load_stall    = ~rst & stall;
  assign stall_busy    = ~rst & busy;
  assign halt_stall_pc = ~rst & hsp;
  assign halt          = ~rst & hlt;

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= RUN;
      br_q <= '0;
      ld_q <= '0;
      hc_q <= '0;
    end else begin
      st_q <= st_d;
      br_q <= br_d;
      ld_q <= ld_d;
      hc_q <= hc_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Randomised + directed bench for hazard_ctrl_unit against
// a timestamp-based reference model of the hazard rules.
module tb_hazard_ctrl_unit;

  localparam int BR = 3;
  localparam int LD = 2;
  localparam int HD = 3;
  localparam logic [3:0] HOPC = 4'hF;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_opcode, id_rs, id_rt, ex_rt;
  logic       id_uses_rs, id_uses_rt, id_mem_write;
  logic       ex_mem_read, mem_branch_taken;
  logic       branch_flush, load_stall, halt_stall_pc;
  logic       halt, stall_busy;

  hazard_ctrl_unit #(
    .REG_W(4), .OPC_W(4), .HALT_OPC(HOPC),
    .BR_FLUSH_CYC(BR), .LD_STALL_CYC(LD),
    .HALT_DRAIN(HD)
  ) dut (
    .clk(clk), .rst(rst),
    .id_opcode(id_opcode), .id_rs(id_rs),
    .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt),
    .id_mem_write(id_mem_write),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .mem_branch_taken(mem_branch_taken),
    .branch_flush(branch_flush),
    .load_stall(load_stall),
    .halt_stall_pc(halt_stall_pc),
    .halt(halt), .stall_busy(stall_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model: absolute cycle timestamps instead of counters
  int t = 0;
  int flush_end = -1000;
  int stall_end = -1000;
  int drain_start = -1;
  bit halted = 1'b0;
  logic [4:0] exp_o;
  logic [4:0] got;

  assign got = {branch_flush, load_stall,
                halt_stall_pc, halt, stall_busy};

  task automatic drive(
    input bit r, input logic [3:0] opc,
    input logic [3:0] rs, input logic [3:0] rt,
    input bit urs, input bit urt, input bit mw,
    input bit emr, input logic [3:0] ert,
    input bit mbt);
    bit f, hzv, s, b, hsp, h;
    rst = r; id_opcode = opc;
    id_rs = rs; id_rt = rt;
    id_uses_rs = urs; id_uses_rt = urt;
    id_mem_write = mw; ex_mem_read = emr;
    ex_rt = ert; mem_branch_taken = mbt;
    f = 0; s = 0; b = 0; hsp = 0; h = 0;
    if (r) begin
      flush_end = -1000; stall_end = -1000;
      drain_start = -1; halted = 0;
    end else begin
      f = mbt || (t <= flush_end);
      if (mbt) flush_end = t + BR - 1;
      hzv = emr && ((urs && !mw && rs == ert) ||
                    (urt && rt == ert)) && !f;
      if (mbt) stall_end = -1000;
      else if (t <= stall_end) begin
        s = 1; b = 1;
      end else if (hzv) begin
        s = 1; stall_end = t + LD - 1;
      end
      if (halted) begin
        hsp = 1; h = 1;
      end else if (drain_start >= 0) begin
        if (mbt) drain_start = -1;
        else begin
          hsp = 1;
          if (t - drain_start >= HD) begin
            h = 1; halted = 1;
          end
        end
      end else if (opc == HOPC && !f && !s) begin
        hsp = 1; drain_start = t;
      end
    end
    exp_o = {f, s, hsp, h, b};
    t++;
  endtask

  task automatic idle();
    drive(0, 4'h0, 4'h0, 4'h0, 0, 0, 0,
          0, 4'h0, 0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive(1, HOPC, 4'h5, 4'h5, 1, 1, 0,
          1, 4'h5, 1);
    #3; checks++;
    if (got !== 5'b0) begin
      errors++;
      $display("FAIL reset got=%b exp=00000", got);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(); #3; checks++;
      if (got !== 5'b0 || got !== exp_o) begin
        errors++;
        $display("FAIL reset_idle c%0d got=%b exp=00000",
                 i, got);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    logic [4:0] p1 = 5'b00111;
    logic [5:0] p2 = 6'b011111;
    for (int i = 0; i < 5; i++) begin
      drive(0, 4'h0, 4'h0, 4'h0, 0, 0, 0,
            0, 4'h0, i == 0);
      #3; checks++;
      if (got !== exp_o || branch_flush !== p1[i]) begin
        errors++;
        $display("FAIL branch c%0d got=%b exp=%b fl=%b",
                 i, got, exp_o, p1[i]);
      end
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      drive(0, 4'h0, 4'h0, 4'h0, 0, 0, 0,
            0, 4'h0, i == 0 || i == 2);
      #3; checks++;
      if (got !== exp_o || branch_flush !== p2[i]) begin
        errors++;
        $display("FAIL retrig c%0d got=%b exp=%b fl=%b",
                 i, got, exp_o, p2[i]);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    logic [2:0] st = 3'b011;
    logic [2:0] bz = 3'b010;
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'h0, 4'h1, 4'h5, 0, i == 0, 0,
            i == 0, 4'h5, 0);
      #3; checks++;
      if (got !== exp_o || load_stall !== st[i] ||
          stall_busy !== bz[i]) begin
        errors++;
        $display("FAIL load_use c%0d got=%b exp=%b",
                 i, got, exp_o);
      end
      tick();
    end
    drive(0, 4'h0, 4'h5, 4'h2, 1, 1, 1,
          1, 4'h5, 0);
    #3; checks++;
    if (got !== exp_o || load_stall !== 1'b0) begin
      errors++;
      $display("FAIL store_rs got=%b exp=%b", got, exp_o);
    end
    tick();
  endtask

  task automatic test_halt();
    for (int i = 0; i < 23; i++) begin
      drive(0, i == 0 ? HOPC : 4'h0, 4'h0, 4'h0,
            0, 0, 0, 0, 4'h0, 0);
      #3; checks++;
      if (got !== exp_o || halt_stall_pc !== 1'b1 ||
          halt !== (i >= 3)) begin
        errors++;
        $display("FAIL halt c%0d got=%b exp=%b",
                 i, got, exp_o);
      end
      tick();
    end
    drive(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 0);
    tick();
  endtask

  task automatic test_cancel();
    logic [5:0] hs = 6'b100001;
    for (int i = 0; i < 6; i++) begin
      drive(0, (i == 0 || i == 5) ? HOPC : 4'h0,
            4'h0, 4'h0, 0, 0, 0, 0, 4'h0, i == 1);
      #3; checks++;
      if (got !== exp_o || halt !== 1'b0 ||
          halt_stall_pc !== hs[i]) begin
        errors++;
        $display("FAIL cancel c%0d got=%b exp=%b",
                 i, got, exp_o);
      end
      tick();
    end
    drive(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 0);
    tick();
  endtask

  task automatic test_collision();
    drive(0, HOPC, 4'h0, 4'h5, 0, 1, 0,
          1, 4'h5, 1);
    #3; checks++;
    if (got !== exp_o || got !== 5'b10000) begin
      errors++;
      $display("FAIL collision got=%b exp=10000", got);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      idle(); #3; checks++;
      if (got !== exp_o || halt_stall_pc !== 1'b0) begin
        errors++;
        $display("FAIL coll_after c%0d got=%b exp=%b",
                 i, got, exp_o);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 59) == 0,
            $urandom_range(0, 5) == 0 ? HOPC :
              4'($urandom_range(0, 14)),
            4'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 4'($urandom_range(0, 3)),
            $urandom_range(0, 9) == 0);
      #3; checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL random c%0d got=%b exp=%b",
                 i, got, exp_o);
      end
      tick();
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_branch();
    test_load_use();
    test_halt();
    test_cancel();
    test_collision();
    test_random();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
